// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, sequencing-controller states, trap causes
// and the per-state control word for the hazard controller.
package pipe_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_IN    = 6'b100100,
    OP_OUT   = 6'b101100,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_BR_WAIT = 3'd1,
    S_IO_WAIT = 3'd2,
    S_HALT    = 3'd3,
    S_TRAP    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_UNDEF = 2'b01,
    CAUSE_IO_TO = 2'b10
  } cause_e;

  typedef struct packed {
    logic pipe_stall;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic io_req;
    logic halted;
  } ctl_t;

  function automatic logic op_reads_rt(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SW) || (op == OP_OUT);
  endfunction

  // Control word a state presents; anything not listed is a full freeze.
  function automatic ctl_t ctl_for(state_e s, logic br_last, logic hlt_exit);
    ctl_t c;
    c = '{pipe_stall: 1'b1, pc_write: 1'b0, ifid_write: 1'b0,
          ifid_flush: 1'b0, io_req: 1'b0, halted: 1'b0};
    case (s)
      S_RUN: begin
        c.pipe_stall = 1'b0;
        c.pc_write   = 1'b1;
        c.ifid_write = 1'b1;
      end
      S_BR_WAIT: begin
        c.pipe_stall = 1'b0;
        c.pc_write   = br_last;
        c.ifid_write = 1'b1;
        c.ifid_flush = 1'b1;
      end
      S_IO_WAIT: c.io_req = 1'b1;
      S_HALT: begin
        if (hlt_exit) begin
          c.pipe_stall = 1'b0;
          c.pc_write   = 1'b1;
          c.ifid_write = 1'b1;
          c.ifid_flush = 1'b1;
        end else begin
          c.halted = 1'b1;
        end
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic [31:0] id_inst;
  logic        undef_inst;
  logic        ex_memr;
  logic [4:0]  ex_rt;
  logic        io_ack;
  logic        resume;
  logic        pipe_stall;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        io_req;
  logic        halted;
  logic        trap;
  logic [1:0]  trap_cause;

  modport master (
    output id_inst, undef_inst, ex_memr, ex_rt, io_ack, resume,
    input  pipe_stall, pc_write, ifid_write, ifid_flush, io_req, halted, trap, trap_cause
  );

  modport slave (
    input  id_inst, undef_inst, ex_memr, ex_rt, io_ack, resume,
    output pipe_stall, pc_write, ifid_write, ifid_flush, io_req, halted, trap, trap_cause
  );
endinterface

// File: rtl/haz_load_use.sv
// Load-use detector: the load in EX writes a register the instruction in ID reads.
module haz_load_use
  import pipe_pkg::*;
(
  input  logic [15:0] id_hi_i,   // id_inst[31:16]: opcode, rs, rt
  input  logic        ex_memr_i,
  input  logic [4:0]  ex_rt_i,
  output logic        lu_o
);

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;

  assign opcode = id_hi_i[15:10];
  assign rs     = id_hi_i[9:5];
  assign rt     = id_hi_i[4:0];

  // $zero never carries a dependency, so a load into r0 is not a hazard.
  assign lu_o = ex_memr_i && (ex_rt_i != 5'd0) &&
                ((ex_rt_i == rs) || (op_reads_rt(opcode) && (ex_rt_i == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch shadow flush, IN/OUT
// handshake, HLT/resume and undefined-opcode trap. Optional macro HAZ_IO_TIMEOUT_EN
// adds an I/O watchdog that traps after IO_TIMEOUT cycles in IO_WAIT.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal flow; load-use bubble applied combinationally
// BR_WAIT   | flushing the branch shadow; PC loads on the last cycle
// IO_WAIT   | frozen with io_req high until io_ack (or watchdog)
// HALT      | frozen after HLT; resume gives one flush+PC-load cycle
// TRAP      | frozen with sticky cause until reset
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_PENALTY = 2,
  parameter int IO_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] br_cnt_q, br_cnt_d;
  logic       io_done_q, io_done_d;
  logic       hlt_exit_q, hlt_exit_d;
  logic       trap_q, trap_d;
  cause_e     cause_q, cause_d;
  ctl_t       ctl_q, ctl_d;

  logic       lu;
  logic       lu_stall;
  logic       ifid_write;
  logic [5:0] opcode;
  logic       unused_inst_lo;

`ifdef HAZ_IO_TIMEOUT_EN
  logic [7:0] io_cnt_q, io_cnt_d;
`else
  logic [7:0] unused_io_timeout;
  assign unused_io_timeout = 8'(IO_TIMEOUT);
`endif

  assign opcode         = bus.id_inst[31:26];
  assign unused_inst_lo = ^bus.id_inst[15:0];

  haz_load_use u_lu (
    .id_hi_i   (bus.id_inst[31:16]),
    .ex_memr_i (bus.ex_memr),
    .ex_rt_i   (bus.ex_rt),
    .lu_o      (lu)
  );

  // An undefined opcode outranks the bubble: it traps rather than stalls.
  assign lu_stall   = (state_q == S_RUN) && lu && !bus.undef_inst;
  assign ifid_write = ctl_q.ifid_write && !lu_stall;

  always_comb begin
    state_d    = state_q;
    br_cnt_d   = br_cnt_q;
    io_done_d  = io_done_q;
    hlt_exit_d = hlt_exit_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
`ifdef HAZ_IO_TIMEOUT_EN
    io_cnt_d   = io_cnt_q;
`endif
    case (state_q)
      S_RUN: begin
        if (bus.undef_inst) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_UNDEF;
        end else if (lu) begin
          state_d = S_RUN;
        end else if (opcode == OP_HLT) begin
          state_d    = S_HALT;
          hlt_exit_d = 1'b0;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
          state_d  = S_BR_WAIT;
          br_cnt_d = 4'(BR_PENALTY);
        end else if (((opcode == OP_IN) || (opcode == OP_OUT)) && !io_done_q) begin
          state_d = S_IO_WAIT;
`ifdef HAZ_IO_TIMEOUT_EN
          io_cnt_d = 8'd0;
`endif
        end
      end
      S_BR_WAIT: begin
        if (br_cnt_q == 4'd1) begin
          state_d  = S_RUN;
          br_cnt_d = 4'd0;
        end else begin
          br_cnt_d = br_cnt_q - 4'd1;
        end
      end
      S_IO_WAIT: begin
        if (bus.io_ack) begin
          state_d   = S_RUN;
          io_done_d = 1'b1;
`ifdef HAZ_IO_TIMEOUT_EN
          io_cnt_d  = 8'd0;
        end else if (io_cnt_q == 8'(IO_TIMEOUT - 1)) begin
          state_d  = S_TRAP;
          trap_d   = 1'b1;
          cause_d  = CAUSE_IO_TO;
          io_cnt_d = 8'd0;
        end else begin
          io_cnt_d = io_cnt_q + 8'd1;
`endif
        end
      end
      S_HALT: begin
        if (hlt_exit_q) begin
          state_d    = S_RUN;
          hlt_exit_d = 1'b0;
        end else if (bus.resume) begin
          hlt_exit_d = 1'b1;
        end
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_RUN;
    endcase
    // The completed IN/OUT is consumed once IF/ID moves on.
    if (ifid_write) io_done_d = 1'b0;
    ctl_d = ctl_for(state_d, br_cnt_d == 4'd1, hlt_exit_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      br_cnt_q   <= 4'd0;
      io_done_q  <= 1'b0;
      hlt_exit_q <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
      ctl_q      <= ctl_for(S_RUN, 1'b0, 1'b0);
`ifdef HAZ_IO_TIMEOUT_EN
      io_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      br_cnt_q   <= br_cnt_d;
      io_done_q  <= io_done_d;
      hlt_exit_q <= hlt_exit_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      ctl_q      <= ctl_d;
`ifdef HAZ_IO_TIMEOUT_EN
      io_cnt_q   <= io_cnt_d;
`endif
    end
  end

  assign bus.pipe_stall = ctl_q.pipe_stall || lu_stall;
  assign bus.pc_write   = ctl_q.pc_write && !lu_stall;
  assign bus.ifid_write = ifid_write;
  assign bus.ifid_flush = ctl_q.ifid_flush;
  assign bus.io_req     = ctl_q.io_req;
  assign bus.halted     = ctl_q.halted;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random instruction streams,
// every cycle checked against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;
  localparam int BRP  = 2;
  localparam int IOTO = 8;

  localparam int M_RUN  = 0;
  localparam int M_BR   = 1;
  localparam int M_IO   = 2;
  localparam int M_HALT = 3;
  localparam int M_TRAP = 4;

  localparam logic [8:0] RESET_VEC = 9'b011_000_0_00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.BR_PENALTY(BRP), .IO_TIMEOUT(IOTO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_mode, m_left, m_wait, m_cause;
  bit m_io_done, m_exit, m_trap;

  int cnt_stall, cnt_flush, cnt_pcw, cnt_ioreq, cnt_halted;

  task automatic m_reset();
    m_mode = M_RUN; m_left = 0; m_wait = 0; m_cause = 0;
    m_io_done = 0; m_exit = 0; m_trap = 0;
  endtask

  function automatic bit m_lu();
    logic [5:0] op;
    bit uses_rt;
    op = bus.id_inst[31:26];
    uses_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43) || (op == 6'd44);
    return bus.ex_memr && (bus.ex_rt != 0) &&
           ((bus.ex_rt == bus.id_inst[25:21]) || (uses_rt && bus.ex_rt == bus.id_inst[20:16]));
  endfunction

  // {pipe_stall, pc_write, ifid_write, ifid_flush, io_req, halted, trap, trap_cause}
  function automatic logic [8:0] m_expect();
    bit ps, pc, iw, fl, rq, hl;
    ps = 0; pc = 1; iw = 1; fl = 0; rq = 0; hl = 0;
    case (m_mode)
      M_RUN:  if (!bus.undef_inst && m_lu()) begin ps = 1; pc = 0; iw = 0; end
      M_BR:   begin pc = (m_left == 1); fl = 1; end
      M_IO:   begin ps = 1; pc = 0; iw = 0; rq = 1; end
      M_HALT: if (m_exit) fl = 1; else begin ps = 1; pc = 0; iw = 0; hl = 1; end
      default: begin ps = 1; pc = 0; iw = 0; end
    endcase
    return {ps, pc, iw, fl, rq, hl, m_trap, 2'(m_cause)};
  endfunction

  task automatic m_step();
    logic [8:0] e;
    logic [5:0] op;
    if (!rst_n) begin m_reset(); return; end
    e  = m_expect();
    op = bus.id_inst[31:26];
    case (m_mode)
      M_RUN: begin
        if (bus.undef_inst) begin m_mode = M_TRAP; m_trap = 1; m_cause = 1; end
        else if (m_lu()) begin end
        else if (op == 6'd63) begin m_mode = M_HALT; m_exit = 0; end
        else if (op == 6'd4 || op == 6'd5) begin m_mode = M_BR; m_left = BRP; end
        else if ((op == 6'd36 || op == 6'd44) && !m_io_done) begin m_mode = M_IO; m_wait = 0; end
      end
      M_BR: begin
        if (m_left == 1) m_mode = M_RUN;
        m_left--;
      end
      M_IO: begin
        if (bus.io_ack) begin m_mode = M_RUN; m_io_done = 1; end
`ifdef HAZ_IO_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == IOTO) begin m_mode = M_TRAP; m_trap = 1; m_cause = 2; end
        end
`endif
      end
      M_HALT: begin
        if (m_exit) begin m_mode = M_RUN; m_exit = 0; end
        else if (bus.resume) m_exit = 1;
      end
      default: ;
    endcase
    if (e[6]) m_io_done = 0;
  endtask

  function automatic logic [8:0] observed();
    return {bus.pipe_stall, bus.pc_write, bus.ifid_write, bus.ifid_flush,
            bus.io_req, bus.halted, bus.trap, bus.trap_cause};
  endfunction

  task automatic tick(input string tag);
    logic [8:0] e, a;
    @(negedge clk);
    e = m_expect();
    a = observed();
    cnt_stall  += int'(bus.pipe_stall);
    cnt_flush  += int'(bus.ifid_flush);
    cnt_pcw    += int'(bus.pc_write);
    cnt_ioreq  += int'(bus.io_req);
    cnt_halted += int'(bus.halted);
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b (stall,pcw,ifidw,flush,ioreq,halt,trap,cause)", tag, a, e);
    end
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_stall = 0; cnt_flush = 0; cnt_pcw = 0; cnt_ioreq = 0; cnt_halted = 0;
  endtask

  task automatic set_idle();
    bus.id_inst = 32'd0; bus.undef_inst = 0; bus.ex_memr = 0; bus.ex_rt = 5'd0;
    bus.io_ack = 0; bus.resume = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    tick("reset");
    tick("reset_hold");
    rst_n = 1;
  endtask

  logic [5:0] ops [10] = '{6'd0, 6'd4, 6'd5, 6'd35, 6'd43, 6'd36, 6'd44, 6'd63, 6'd8, 6'd48};

  initial begin
    logic [5:0] op;
    logic [8:0] a;
    int trap_age;
    set_idle();
    m_reset();
    clear_counts();
    do_reset();
    tick("run_idle");

    // load-use on rs, then with ex_rt = 0
    clear_counts();
    bus.id_inst = {6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20};
    bus.ex_memr = 1; bus.ex_rt = 5'd5;
    tick("lu_stall");
    bus.ex_memr = 0;
    tick("lu_release");
    check_int("lu_stall_cycles", cnt_stall, 1);
    bus.ex_memr = 1; bus.ex_rt = 5'd0;
    tick("lu_rt_zero");
    bus.ex_memr = 0;

    // beq shadow
    bus.id_inst = {6'd4, 5'd1, 5'd2, 16'd8};
    tick("br_detect");
    clear_counts();
    bus.id_inst = 32'd0;
    tick("br_wait1");
    tick("br_wait2");
    check_int("br_flush_cycles", cnt_flush, BRP);
    check_int("br_pcw_cycles", cnt_pcw, 1);
    tick("br_back_run");

    // IN with ack on the 4th waiting cycle
    bus.id_inst = {6'd36, 5'd0, 5'd3, 16'h0010};
    tick("in_detect");
    clear_counts();
    tick("in_wait1");
    tick("in_wait2");
    tick("in_wait3");
    bus.io_ack = 1;
    tick("in_wait4_ack");
    bus.io_ack = 0;
    tick("in_pass");
    bus.id_inst = 32'd0;
    tick("in_next");
    check_int("in_ioreq_cycles", cnt_ioreq, 4);

    // undefined opcode traps; resume is ignored
    bus.id_inst = {6'b110000, 26'd0}; bus.undef_inst = 1;
    tick("undef_detect");
    set_idle();
    tick("trap1");
    bus.resume = 1;
    tick("trap_resume");
    bus.resume = 0; bus.io_ack = 1;
    tick("trap_ack");
    bus.io_ack = 0;
    tick("trap_hold");
    do_reset();

    // HLT, resume on the 10th halted cycle
    bus.id_inst = 32'hFC00_0000;
    tick("hlt_detect");
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      bus.resume = (i == 9);
      tick("halted");
    end
    bus.resume = 0;
    check_int("halted_cycles", cnt_halted, 10);
    tick("hlt_exit");
    bus.id_inst = 32'd0;
    tick("hlt_run");

    // async reset in the middle of HALT
    bus.id_inst = 32'hFC00_0000;
    tick("hlt2_detect");
    tick("hlt2_a");
    tick("hlt2_b");
    rst_n = 0;
    #1;
    a = observed();
    total++;
    assert (a === RESET_VEC) else begin
      bad++;
      $error("FAIL async_reset: observed=%b expected=%b", a, RESET_VEC);
    end
    m_reset();
    set_idle();
    tick("reset_in_halt");
    rst_n = 1;
    tick("after_reset");

    // OUT with no ack
    bus.id_inst = {6'd44, 5'd2, 5'd4, 16'h0020};
    tick("out_detect");
    bus.id_inst = {6'd44, 5'd2, 5'd4, 16'h0020};
    for (int i = 0; i < 12; i++) tick("out_wait");
`ifdef HAZ_IO_TIMEOUT_EN
    check_int("io_timeout_trap", int'(bus.trap), 1);
    check_int("io_timeout_cause", int'(bus.trap_cause), 2);
    check_int("io_timeout_req", int'(bus.io_req), 0);
`else
    check_int("io_wait_req_held", int'(bus.io_req), 1);
    check_int("io_wait_no_trap", int'(bus.trap), 0);
`endif
    set_idle();
    do_reset();

    // random streams
    trap_age = 0;
    for (int i = 0; i < 3000; i++) begin
      op = ops[$urandom_range(0, 9)];
      bus.id_inst    = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      bus.undef_inst = (op == 6'b110000) && ($urandom_range(0, 3) == 0);
      bus.ex_memr    = 1'($urandom_range(0, 1));
      bus.ex_rt      = 5'($urandom_range(0, 3));
      bus.io_ack     = ($urandom_range(0, 3) == 0);
      bus.resume     = ($urandom_range(0, 5) == 0);
      tick("rand");
      if (m_mode == M_TRAP) trap_age++;
      if (trap_age > 4) begin
        set_idle();
        do_reset();
        trap_age = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
